// File: rtl/scmi_doorbell_arbiter.sv
// scmi_doorbell_arbiter
//   Converts per-channel level doorbells from the SCMI mailbox into sticky pending bits,
//   round-robin arbitrates pending unmasked channels and offers one channel at a time to
//   the PMS core as a valid/ready interrupt token.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   doorbell_i     level doorbell IRQs (synchronous to clk_i)
//   mask_i         1 = channel excluded from arbitration (pending still recorded)
//   irq_valid_o    interrupt token valid
//   chan_id_o      granted channel; stable while irq_valid_o && !irq_ready_i
//   irq_ready_i    core accepts token
//   pending_o      current pending bits
//   overrun_o      sticky overrun flags
//   overrun_clr_i  per-bit clear pulse for overrun_o
module scmi_doorbell_arbiter #(
  parameter int unsigned NumChannels = 64,
  localparam int unsigned ChanIdWidth = $clog2(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] doorbell_i,
  input  logic [NumChannels-1:0] mask_i,
  output logic                   irq_valid_o,
  output logic [ChanIdWidth-1:0] chan_id_o,
  input  logic                   irq_ready_i,
  output logic [NumChannels-1:0] pending_o,
  output logic [NumChannels-1:0] overrun_o,
  input  logic [NumChannels-1:0] overrun_clr_i
);

  localparam logic [ChanIdWidth-1:0] LastIdx = ChanIdWidth'(NumChannels - 1);

  typedef enum logic {StIdle, StOffer} state_e;

  state_e                 state_q, state_d;
  logic [NumChannels-1:0] hist_q;
  logic [NumChannels-1:0] pending_q, pending_d;
  logic [NumChannels-1:0] overrun_q, overrun_d;
  logic [ChanIdWidth-1:0] ptr_q, ptr_d;
  logic [ChanIdWidth-1:0] chan_q, chan_d;

  logic [NumChannels-1:0] rise;
  logic [NumChannels-1:0] clr_vec;
  logic [NumChannels-1:0] eligible;
  logic                   handshake;
  logic [ChanIdWidth-1:0] grant_hi, grant_any, grant;
  logic                   found_hi;

  assign rise      = doorbell_i & ~hist_q;
  assign eligible  = pending_q & ~mask_i;
  assign handshake = (state_q == StOffer) && irq_ready_i;

  always_comb begin
    clr_vec = '0;
    if (handshake) begin
      clr_vec[chan_q] = 1'b1;
    end
  end

  // A new edge wins over a same-cycle handshake clear; such an edge is not an overrun.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | rise;
    overrun_d = (overrun_q & ~overrun_clr_i) | (rise & pending_q & ~clr_vec);
  end

  // Round-robin: lowest eligible index >= ptr, else lowest eligible overall (wrap).
  // Scanning downward lets the last hit be the lowest index.
  always_comb begin
    grant_hi  = '0;
    grant_any = '0;
    found_hi  = 1'b0;
    for (int i = int'(NumChannels) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_any = ChanIdWidth'(i);
        if (ChanIdWidth'(i) >= ptr_q) begin
          grant_hi = ChanIdWidth'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_any;
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state plus the grant / pointer registers it drives
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (eligible != '0) begin
          chan_d  = grant;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (irq_ready_i) begin
          ptr_d   = (chan_q == LastIdx) ? '0 : chan_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq_valid_o = (state_q == StOffer);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      ptr_q     <= '0;
      chan_q    <= '0;
    end else begin
      hist_q    <= doorbell_i;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      ptr_q     <= ptr_d;
      chan_q    <= chan_d;
    end
  end

  assign chan_id_o = chan_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_scmi_doorbell_arbiter.sv
module tb_scmi_doorbell_arbiter;

  localparam int N = 64;

  logic         clk;
  logic         rst;
  logic [N-1:0] doorbell;
  logic [N-1:0] mask;
  logic         irq_valid;
  logic [5:0]   chan_id;
  logic         irq_ready;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic [N-1:0] overrun_clr;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [N-1:0] m_hist, m_pend, m_ovr;
  int           m_ptr, m_chan;
  bit           m_offer;

  scmi_doorbell_arbiter #(.NumChannels(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .doorbell_i   (doorbell),
    .mask_i       (mask),
    .irq_valid_o  (irq_valid),
    .chan_id_o    (chan_id),
    .irq_ready_i  (irq_ready),
    .pending_o    (pending),
    .overrun_o    (overrun),
    .overrun_clr_i(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_hist  = '0;
    m_pend  = '0;
    m_ovr   = '0;
    m_ptr   = 0;
    m_chan  = 0;
    m_offer = 1'b0;
  endfunction

  // One clock of the behavioural model, using the inputs present at the edge.
  function automatic void model_step();
    logic [N-1:0] np, no;
    bit hs, found;
    hs = m_offer && irq_ready;
    np = m_pend;
    no = m_ovr;
    for (int i = 0; i < N; i++) begin
      bit r, c;
      r = doorbell[i] && !m_hist[i];
      c = hs && (m_chan == i);
      if (overrun_clr[i]) no[i] = 1'b0;
      if (r && m_pend[i] && !c) no[i] = 1'b1;
      if (c) np[i] = 1'b0;
      if (r) np[i] = 1'b1;
    end
    if (m_offer) begin
      if (irq_ready) begin
        m_offer = 1'b0;
        m_ptr   = (m_chan + 1) % N;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && m_pend[idx] && !mask[idx]) begin
          found   = 1'b1;
          m_chan  = idx;
          m_offer = 1'b1;
        end
      end
    end
    m_hist = doorbell;
    m_pend = np;
    m_ovr  = no;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset(input logic [N-1:0] db_init);
    rst         = 1'b1;
    doorbell    = db_init;
    mask        = '0;
    irq_ready   = 1'b0;
    overrun_clr = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] db;
    db    = '0;
    db[5] = 1'b1;
    rst   = 1'b1;
    doorbell = db;
    #1;
    n_checks++;
    if (irq_valid !== 1'b0 || chan_id !== 6'd0 || pending !== '0 || overrun !== '0)
      $display("FAIL reset_state: valid=%b chan=%0d pend=%h ovr=%h, required 0/0/0/0",
               irq_valid, chan_id, pending, overrun);
    else n_pass++;
    apply_reset(db);
    tick();
    n_checks++;
    if (pending[5] !== 1'b1 || irq_valid !== 1'b0)
      $display("FAIL reset_edge_cycle1: pend5=%b valid=%b, required 1/0", pending[5], irq_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || chan_id !== 6'd5)
      $display("FAIL reset_edge_cycle2: valid=%b chan=%0d, required 1/5", irq_valid, chan_id);
    else n_pass++;
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    doorbell  = '0;
    tick();
  endtask

  task automatic collect_tokens(output int q[$]);
    q = {};
    for (int c = 0; c < 20; c++) begin
      if (irq_valid && irq_ready) q.push_back(int'(chan_id));
      tick();
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    logic [N-1:0] db;
    apply_reset('0);
    irq_ready = 1'b1;
    db = '0;
    db[3] = 1'b1; db[10] = 1'b1; db[60] = 1'b1;
    doorbell = db;
    tick();
    doorbell = '0;
    collect_tokens(got);
    n_checks++;
    if (got.size() != 3 || got[0] != 3 || got[1] != 10 || got[2] != 60)
      $display("FAIL rr_order: got %p, required '{3, 10, 60}", got);
    else n_pass++;
    db = '0;
    db[3] = 1'b1;
    doorbell = db;
    tick();
    doorbell = '0;
    collect_tokens(got);
    n_checks++;
    if (got.size() != 1 || got[0] != 3)
      $display("FAIL rr_wrap: got %p, required '{3}", got);
    else n_pass++;
    irq_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [N-1:0] db;
    int waited;
    apply_reset('0);
    db = '0;
    db[7] = 1'b1;
    doorbell = db;
    tick();
    doorbell = '0;
    waited = 0;
    while (!irq_valid && waited < 5) begin
      tick();
      waited++;
    end
    n_checks++;
    if (irq_valid !== 1'b1) $display("FAIL hold_wait: valid=%b, required 1 within 5 cycles", irq_valid);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) mask[7] = 1'b1;
      tick();
      n_checks++;
      if (irq_valid !== 1'b1 || chan_id !== 6'd7)
        $display("FAIL hold_stable: cycle %0d valid=%b chan=%0d, required 1/7", c, irq_valid, chan_id);
      else n_pass++;
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    mask = '0;
    tick();
    n_checks++;
    if (irq_valid !== 1'b0 || pending[7] !== 1'b0)
      $display("FAIL hold_accept: valid=%b pend7=%b, required 0/0", irq_valid, pending[7]);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [N-1:0] db;
    apply_reset('0);
    db = '0;
    db[2] = 1'b1;
    doorbell = db;
    tick();
    doorbell = '0;
    tick();
    doorbell = db;
    tick();
    doorbell = '0;
    n_checks++;
    if (overrun[2] !== 1'b1 || pending[2] !== 1'b1)
      $display("FAIL overrun_set: ovr2=%b pend2=%b, required 1/1", overrun[2], pending[2]);
    else n_pass++;
    overrun_clr[2] = 1'b1;
    tick();
    overrun_clr = '0;
    n_checks++;
    if (overrun[2] !== 1'b0 || pending[2] !== 1'b1)
      $display("FAIL overrun_clr: ovr2=%b pend2=%b, required 0/1", overrun[2], pending[2]);
    else n_pass++;
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    logic [N-1:0] db;
    apply_reset('0);
    mask[4] = 1'b1;
    db = '0;
    db[4] = 1'b1;
    doorbell = db;
    tick();
    doorbell = '0;
    tick(); tick(); tick();
    n_checks++;
    if (pending[4] !== 1'b1 || irq_valid !== 1'b0)
      $display("FAIL mask_hold: pend4=%b valid=%b, required 1/0", pending[4], irq_valid);
    else n_pass++;
    mask = '0;
    tick();
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || chan_id !== 6'd4)
      $display("FAIL mask_release: valid=%b chan=%0d, required 1/4", irq_valid, chan_id);
    else n_pass++;
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
  endtask

  task automatic test_reset_mid_offer();
    logic [N-1:0] db;
    apply_reset('0);
    db = '0;
    db[9] = 1'b1; db[20] = 1'b1;
    doorbell = db;
    tick();
    doorbell = '0;
    tick();
    db = '0;
    db[20] = 1'b1;
    doorbell = db;
    tick();
    doorbell = '0;
    n_checks++;
    if (irq_valid !== 1'b1 || chan_id !== 6'd9 || overrun[20] !== 1'b1)
      $display("FAIL midrst_setup: valid=%b chan=%0d ovr20=%b, required 1/9/1",
               irq_valid, chan_id, overrun[20]);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (irq_valid !== 1'b0 || pending !== '0 || overrun !== '0)
      $display("FAIL midrst_async: valid=%b pend=%h ovr=%h, required 0/0/0",
               irq_valid, pending, overrun);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    apply_reset('0);
    for (int c = 0; c < 1500; c++) begin
      doorbell = doorbell ^ ({$urandom(), $urandom()} & {$urandom(), $urandom()} &
                             {$urandom(), $urandom()});
      if ($urandom_range(0, 15) == 0)
        mask = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      irq_ready = ($urandom_range(0, 2) != 0);
      overrun_clr = ($urandom_range(0, 7) == 0) ? {$urandom(), $urandom()} : '0;
      tick();
      n_checks++;
      if (irq_valid !== m_offer)
        $display("FAIL rand_valid: cycle %0d got %b required %b", c, irq_valid, m_offer);
      else n_pass++;
      n_checks++;
      if (chan_id !== 6'(m_chan))
        $display("FAIL rand_chan: cycle %0d got %0d required %0d", c, chan_id, m_chan);
      else n_pass++;
      n_checks++;
      if (pending !== m_pend)
        $display("FAIL rand_pending: cycle %0d got %h required %h", c, pending, m_pend);
      else n_pass++;
      n_checks++;
      if (overrun !== m_ovr)
        $display("FAIL rand_overrun: cycle %0d got %h required %h", c, overrun, m_ovr);
      else n_pass++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    doorbell    = '0;
    mask        = '0;
    irq_ready   = 1'b0;
    overrun_clr = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_hold();
    test_overrun();
    test_mask();
    test_reset_mid_offer();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
